// File: rtl/mul_share_arbiter_if.sv
// Requester-side and multiplier-side signals of the shared-multiplier arbiter.
// The master modport is the environment (requesters and multiplier); slave is the arbiter.
interface mul_share_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   rsp_valid;
    logic [15:0]       rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              mul_reset;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic              mul_ready;
    logic [15:0]       mul_out;

    modport master (
        output req_valid, req_a, req_b, mul_ready, mul_out,
        input  req_ack, rsp_valid, rsp_data, rsp_err, busy, mul_reset, mul_a, mul_b
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_ready, mul_out,
        output req_ack, rsp_valid, rsp_data, rsp_err, busy, mul_reset, mul_a, mul_b
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one shift-add multiplier among NREQ requesters.
// state | meaning
// IDLE  | no operation in flight; arbitrate among req_valid
// ISSUE | pulse mul_reset and req_ack to the granted requester
// WAIT  | wait for mul_ready, abort after TIMEOUT cycles
// DONE  | pulse rsp_valid to the granted requester
module mul_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    mul_share_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state_q, state_d;

    logic [IDW-1:0]  rr_last;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  grant_id;
    logic            grant_vld;
    logic [IDW:0]    cand;
    logic [7:0]      wait_cnt;
    logic [7:0]      mul_a_q;
    logic [7:0]      mul_b_q;
    logic [15:0]     rsp_data_q;
    logic            rsp_err_q;
    logic            timeout_hit;
    logic [NREQ-1:0] req_ack_d;
    logic [NREQ-1:0] rsp_valid_d;
    logic            mul_reset_d;
    logic            busy_d;

    // wait_cnt is 0 in the first WAIT cycle, so this fires on WAIT cycle number TIMEOUT
    assign timeout_hit = (({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_vld   = 1'b0;
        grant_id    = '0;
        cand        = '0;
        req_ack_d   = '0;
        rsp_valid_d = '0;
        mul_reset_d = 1'b0;
        busy_d      = (state_q != IDLE);

        for (int i = 1; i <= NREQ; i++) begin
            cand = (IDW+1)'(rr_last) + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_vld && bus.req_valid[cand[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = cand[IDW-1:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mul_reset_d     = 1'b1;
                req_ack_d[id_q] = 1'b1;
                state_d         = WAIT;
            end
            WAIT: begin
                if (bus.mul_ready || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid_d[id_q] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last    <= IDW'(NREQ - 1);
            id_q       <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            wait_cnt   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        id_q    <= grant_id;
                        rr_last <= grant_id;
                        mul_a_q <= bus.req_a[{grant_id, 3'b000} +: 8];
                        mul_b_q <= bus.req_b[{grant_id, 3'b000} +: 8];
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // a ready in the same cycle as the timeout still wins
                    if (bus.mul_ready) begin
                        rsp_data_q <= bus.mul_out;
                        rsp_err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ack   = req_ack_d;
    assign bus.rsp_valid = rsp_valid_d;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_d;
    assign bus.mul_reset = mul_reset_d;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;

    a_onehot_pulses: assert property (@(posedge clk) disable iff (reset)
        $onehot0({req_ack_d, rsp_valid_d}))
        else $error("req_ack/rsp_valid not one-hot-or-zero");
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one 8x8 shift-add multiplier among NREQ requesters.
- Performs round-robin arbitration and sequences the multiplier's load/compute/ready protocol.
- Returns each 16-bit product to the requester that issued it.
- Sits between requester blocks and a single multiplier instance. Drives the multiplier's reset/a/b and samples its ready/out.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 16, maximum WAIT cycles before the operation is aborted (1..255). The longest legal WAIT is 10.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  per-requester request. Held until req_ack.
- req_a  in  8*NREQ  operand a. Requester i occupies bits [8i+7:8i].
- req_b  in  8*NREQ  operand b, same packing as req_a.
- req_ack  out  NREQ  one-cycle pulse: operands latched.
- rsp_valid  out  NREQ  one-cycle pulse: result for requester i.
- rsp_data  out  16  product. Valid while any rsp_valid bit is set.
- rsp_err  out  1  timeout flag. Qualified by rsp_valid.
- busy  out  1  high in every state except IDLE.
- mul_reset  out  1  multiplier load strobe.
- mul_a  out  8  multiplier operand a.
- mul_b  out  8  multiplier operand b.
- mul_ready  in  1  multiplier done.
- mul_out  in  16  multiplier product.

Behaviour:
- Reset values:
  - state=IDLE.
  - req_ack=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
  - mul_reset=0, mul_a=0, mul_b=0.
  - rr_last=NREQ-1, so requester 0 has first priority.
  - wait counter=0.
- Reset mid-operation aborts the operation. No rsp_valid is issued for it, and the in-flight requester must re-request.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from rr_last+1 upward, with wrap-around.
  - At the clock edge: latch that requester's a/b into mul_a/mul_b, record the grant id, set rr_last=id, go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mul_reset=1 and req_ack[id]=1. Both are decoded from the registered state only.
  - mul_ready is ignored here, because it may still be 1 from the previous operation.
  - Go to WAIT and clear the wait counter.
- WAIT:
  - mul_reset=0. The wait counter increments each cycle.
  - If mul_ready=1: capture mul_out into rsp_data, set rsp_err=0, go to DONE.
  - Else if the counter reaches TIMEOUT: set rsp_data=0 and rsp_err=1, go to DONE.
  - mul_ready has priority over timeout when both occur in the same cycle.
- DONE (exactly 1 cycle):
  - rsp_valid[id]=1. rsp_data and rsp_err hold until the next DONE.
  - Go to IDLE.
- Latency, with the request first seen in IDLE cycle T:
  - ISSUE at T+1.
  - WAIT for bitlen(b)+2 cycles, where bitlen(0)=0.
  - DONE at T+bitlen(b)+4.
  - Examples: b=0 -> DONE at T+4; b=255 -> DONE at T+12.
- Back-to-back throughput: the next grant is evaluated in the IDLE cycle after DONE. No arbitration happens during busy.
- If req_valid drops before req_ack, the request is not served. If it is dropped during IDLE, it simply loses arbitration.
- If req_valid is still high in the IDLE after DONE, it is treated as a new request.
- The operands on req_a/req_b are sampled only at the IDLE->ISSUE edge. Later changes have no effect on the operation in flight.
- mul_a/mul_b hold their values from ISSUE through DONE.
- Exactly one bit of req_ack or rsp_valid is ever set (one-hot or zero). This is checked by assertion.

Test Plan:
- Single request: req 0 with a=3, b=5 seen at T -> req_ack[0] at T+1, mul_reset high for 1 cycle, rsp_valid[0] at T+7, rsp_data=15, rsp_err=0.
- Round-robin: all four requesters held valid with distinct operands -> grants in order 0,1,2,3,0. Each rsp_valid goes only to the granted id, with the correct product.
- Boundaries:
  - a=0, b=200 -> 0.
  - a=7, b=0 -> 0, DONE at T+4.
  - a=255, b=255 -> 65025, DONE at T+12.
- Stale ready: the bench model keeps mul_ready=1 through ISSUE from the previous op -> it is ignored, and the new result is correct.
- Timeout: the model holds mul_ready=0 -> after 16 WAIT cycles, rsp_valid[id]=1, rsp_err=1, rsp_data=0. The next request completes normally.
- Reset mid-WAIT: assert reset for 1 cycle -> next cycle all outputs are at reset values with no rsp_valid. A subsequent request from requester 2 (others idle) is granted and completes correctly.
